// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes, FSM state
// encodings and the frame-length helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  function automatic int unsigned bits_per_frame(input int unsigned data_bits,
                                                 input int unsigned parity,
                                                 input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with configurable character format and valid/ready handshakes.
// Define UART_RX_FIFO_EN to buffer received characters in an RX_FIFO_DEPTH FIFO.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 1302,
  parameter int unsigned DATA_BITS     = 7,
  parameter int unsigned PARITY        = 1,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun_error
);

  localparam int unsigned CW        = $clog2(STOP_BITS * CLK_DIV + 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * CLK_DIV);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic          ODD       = (PARITY == PAR_ODD);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("uart_transceiver: CLK_DIV must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_transceiver: DATA_BITS must be 5..8");
  end
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_transceiver: RX_FIFO_DEPTH must be a power of 2, at least 2");
  end

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_par;

  assign tx_ready = (tx_state == TX_IDLE);

  // STOP loads CLK_DIV*STOP_BITS rather than minus one: the extra cycle is the
  // guaranteed idle-high gap before the next frame can be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else if (tx_state != TX_IDLE && tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_valid) begin
          tx_shift <= tx_data & DATA_MASK;
          tx_par   <= ^(tx_data & DATA_MASK) ^ ODD;
          tx       <= 1'b0;
          tx_cnt   <= BIT_LOAD;
          tx_state <= TX_START;
        end
        TX_START: begin
          tx       <= tx_shift[0];
          tx_bit   <= '0;
          tx_cnt   <= BIT_LOAD;
          tx_state <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_bit == LAST_BIT) begin
            if (HAS_PAR) begin
              tx       <= tx_par;
              tx_cnt   <= BIT_LOAD;
              tx_state <= TX_PARITY;
            end else begin
              tx       <= 1'b1;
              tx_cnt   <= STOP_LOAD;
              tx_state <= TX_STOP;
            end
          end else begin
            tx       <= tx_shift[1];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 1'b1;
            tx_cnt   <= BIT_LOAD;
          end
        end
        TX_PARITY: begin
          tx       <= 1'b1;
          tx_cnt   <= STOP_LOAD;
          tx_state <= TX_STOP;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic          rx_m;
  logic          rx_s;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_perr;
  logic          rx_done;
  logic [9:0]    rx_char;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign rx_done = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_char = {~rx_s, rx_perr, rx_shift};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
    end else if (rx_state != RX_IDLE && rx_state != RX_BREAK && rx_cnt != '0) begin
      rx_cnt <= rx_cnt - 1'b1;
    end else begin
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_cnt   <= HALF_LOAD;
          rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_s) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_bit   <= '0;
            rx_cnt   <= BIT_LOAD;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          rx_shift[rx_bit] <= rx_s;
          rx_cnt           <= BIT_LOAD;
          if (rx_bit == LAST_BIT) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
          else                    rx_bit   <= rx_bit + 1'b1;
        end
        RX_PARITY: begin
          rx_perr  <= rx_s ^ (^rx_shift) ^ ODD;
          rx_cnt   <= BIT_LOAD;
          rx_state <= RX_STOP;
        end
        RX_STOP:  rx_state <= rx_s ? RX_IDLE : RX_BREAK;
        RX_BREAK: if (rx_s) rx_state <= RX_IDLE;
        default:  rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [9:0] out_word;
  logic       ovr;

`ifdef UART_RX_FIFO_EN
  logic [9:0] fifo_out;
  logic       fifo_empty;
  logic       fifo_full;

  uart_rx_fifo #(.WIDTH(10), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_done),
    .push_data (rx_char),
    .pop       (rx_valid && rx_ready),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rx_valid = !fifo_empty;
  assign out_word = fifo_empty ? '0 : fifo_out;

  always_ff @(posedge clk) begin
    if (reset) ovr <= 1'b0;
    else       ovr <= rx_done && fifo_full && !rx_ready;
  end
`else
  logic [9:0] hold;
  logic       hold_valid;

  assign rx_valid = hold_valid;
  assign out_word = hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (rx_done && (!hold_valid || rx_ready)) begin
        hold       <= rx_char;
        hold_valid <= 1'b1;
      end else begin
        if (rx_done)                hold_valid <= hold_valid;
        if (rx_done)                ovr        <= 1'b1;
        if (hold_valid && rx_ready) hold_valid <= 1'b0;
      end
    end
  end
`endif

  assign rx_data       = out_word[7:0];
  assign parity_error  = out_word[8];
  assign framing_error = out_word[9];
  assign overrun_error = ovr;

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench: a 7E1 instance driven directly on rx, and an 8O2 instance in loopback.
module tb_uart_transceiver;

  localparam int unsigned BIT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready_a, tx_ready_b;
  logic       tx_a, tx_b;
  logic       rx_a;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       rx_ready_a, rx_ready_b;
  logic       perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;

  int checks = 0;
  int errors = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;
  int ready_at;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic [9:0] got_a, got_b;
  logic [9:0] exp_tx;

  always #5 clk = ~clk;

  uart_transceiver #(.CLK_DIV(BIT), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_dut_7e1 (
    .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .tx(tx_a), .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .parity_error(perr_a), .framing_error(ferr_a), .overrun_error(ovr_a)
  );

  uart_transceiver #(.CLK_DIV(BIT), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) u_dut_8o2 (
    .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .tx(tx_b), .rx(tx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .parity_error(perr_b), .framing_error(ferr_b), .overrun_error(ovr_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
      if (rx_valid_a && rx_ready_a) begin
        got_a = {ferr_a, perr_a, rx_data_a};
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_a_unexpected got %h expected nothing", got_a);
        end else check("rx_a_char", got_a, q_a.pop_front());
      end
      if (rx_valid_b && rx_ready_b) begin
        got_b = {ferr_b, perr_b, rx_data_b};
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_b_unexpected got %h expected nothing", got_b);
        end else check("rx_b_char", got_b, q_b.pop_front());
      end
    end
  end

  // Word bit 0 goes on the line first: {stop, parity, data[6:0], start}.
  task automatic drive_rx_a(input logic [9:0] w);
    for (int i = 0; i < 10; i++) begin
      rx_a = w[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, q_a.size() + q_b.size(), 0);
  endtask

  task automatic wait_ready_b(input string name);
    int n = 0;
    @(negedge clk);
    while (!tx_ready_b && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_ready_b, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_data_a = '0; tx_data_b = '0;
    rx_a = 1'b1; rx_ready_a = 1'b1; rx_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_tx", tx_a, 1);
    check("reset_tx_ready", tx_ready_a, 1);
    check("reset_rx_valid", rx_valid_a, 0);
    check("reset_rx_data", rx_data_a, 0);
    check("reset_flags", {perr_a, ferr_a, ovr_a}, 0);
    check("reset_tx_b", tx_b, 1);

    // 7E1 transmit of 0x41 (bit 7 of 0xC1 must be ignored)
    exp_tx = 10'b1_0_1000001_0;
    tx_data_a = 8'hC1; tx_valid_a = 1'b1;
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
    ready_at = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (n % BIT == 8 && n < 160) check($sformatf("tx_bit%0d", n / BIT), tx_a, exp_tx[n / BIT]);
      if (tx_ready_a) begin
        ready_at = n;
        break;
      end
    end
    check("tx_ready_latency", ready_at, 161);
    check("tx_idle_high", tx_a, 1);

    // Reset in the middle of a data bit
    @(negedge clk);
    tx_data_a = 8'h00; tx_valid_a = 1'b1;
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("tx_low_before_abort", tx_a, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_tx_high", tx_a, 1);
    check("abort_tx_ready", tx_ready_a, 1);

    // 8O2 loopback with tx_valid held across both characters
    tx_data_b = 8'h55; tx_valid_b = 1'b1;
    q_b.push_back({2'b00, 8'h55});
    wait_ready_b("tx_b_handshake1");
    tx_data_b = 8'hA3;
    q_b.push_back({2'b00, 8'hA3});
    wait_ready_b("tx_b_handshake2");
    tx_valid_b = 1'b0;
    wait_drain("loopback_drain");

    // 7E1 receive: good frame, then parity error
    q_a.push_back({2'b00, 8'h41});
    drive_rx_a({1'b1, 1'b0, 7'h41, 1'b0});
    q_a.push_back({2'b01, 8'h41});
    drive_rx_a({1'b1, 1'b1, 7'h41, 1'b0});

    // Stop bit 0 then line held low: one framing-error character only
    q_a.push_back({2'b10, 8'h00});
    drive_rx_a(10'b0);
    repeat (200) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    check("break_single_char", q_a.size(), 0);
    q_a.push_back({2'b00, 8'h2A});
    drive_rx_a({1'b1, 1'b1, 7'h2A, 1'b0});

    // Short low pulse is rejected, following frame still received
    rx_a = 1'b0;
    repeat (6) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_no_valid", rx_valid_a, 0);
    q_a.push_back({2'b00, 8'h41});
    drive_rx_a({1'b1, 1'b0, 7'h41, 1'b0});
    wait_drain("rx_a_drain");

    // Five characters with the consumer stalled
    rx_ready_a = 1'b0;
`ifdef UART_RX_FIFO_EN
    q_a.push_back({2'b00, 8'h01}); q_a.push_back({2'b00, 8'h02});
    q_a.push_back({2'b00, 8'h03}); q_a.push_back({2'b00, 8'h04});
`else
    q_a.push_back({2'b00, 8'h01});
`endif
    drive_rx_a({1'b1, 1'b1, 7'h01, 1'b0});
    drive_rx_a({1'b1, 1'b1, 7'h02, 1'b0});
    drive_rx_a({1'b1, 1'b0, 7'h03, 1'b0});
    drive_rx_a({1'b1, 1'b1, 7'h04, 1'b0});
    drive_rx_a({1'b1, 1'b0, 7'h05, 1'b0});
    repeat (20) @(posedge clk);
    @(negedge clk);
`ifdef UART_RX_FIFO_EN
    check("overrun_pulses", ovr_cnt_a, 1);
`else
    check("overrun_pulses", ovr_cnt_a, 4);
`endif
    check("stall_valid", rx_valid_a, 1);
    check("stall_head_char", {ferr_a, perr_a, rx_data_a}, {2'b00, 8'h01});
    rx_ready_a = 1'b1;
    wait_drain("overrun_drain");
    repeat (5) @(negedge clk);
    check("empty_after_drain", rx_valid_a, 0);
    check("loopback_no_overrun", ovr_cnt_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Parametrised full-duplex UART core replacing the fixed 7-bit/parity-only transmitter and receiver pair. It takes a CLK_DIV-cycle bit period, a configurable character format (data bits, parity mode, stop bits) and valid/ready handshakes on both directions. The receiver adds glitch rejection and reports framing, parity and overrun status per character. It sits between the board-level switch/button/seven-segment logic and the serial pins.

## Interface
- CLK_DIV, 1302: clock cycles per bit (50 MHz / 38400); ≥ 4
- DATA_BITS, 7: character length, 5..8
- PARITY, 1: 0 none, 1 even, 2 odd
- STOP_BITS, 1: 1 or 2
- RX_FIFO_DEPTH, 4: power of 2, ≥ 2; used only with UART_RX_FIFO_EN
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- tx_data  in  8  character to send; bits above DATA_BITS ignored
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  transmitter idle, accepts on tx_valid&&tx_ready
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous
- rx_data  out  8  received character, zero-extended above DATA_BITS
- rx_valid  out  1  rx_data/flags valid
- rx_ready  in  1  consumer pops on rx_valid&&rx_ready
- parity_error  out  1  qualifies rx_data; always 0 when PARITY=0
- framing_error  out  1  qualifies rx_data; first stop bit sampled 0
- overrun_error  out  1  one-cycle pulse, character dropped

## Operation
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error outputs 0. Both FSMs go to IDLE. The rx synchroniser flops reset to 1. The FIFO is emptied.
- Reset mid-frame aborts the frame: tx is high on the cycle after reset is sampled, and the partial rx character is discarded.
- TX FSM: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - tx_ready = (state==IDLE).
  - The character is latched on the handshake.
  - Each bit is held exactly CLK_DIV cycles. Data is sent LSB first.
  - Parity covers DATA_BITS bits. Even: XOR of the bits. Odd: its inverse.
  - STOP lasts STOP_BITS×CLK_DIV cycles.
- RX front end: 2-flop synchroniser; rx_s is the synchronised value.
- RX FSM: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE/BREAK.
  - In IDLE, rx_s==0 enters START and loads the counter for CLK_DIV/2 (integer division).
  - At mid-start, rx_s==1 means a glitch: return to IDLE with no output. Otherwise proceed.
  - Data, parity and stop are sampled every CLK_DIV cycles after mid-start.
  - Only the first stop bit is checked. The FSM returns to IDLE immediately after the stop sample, so it can detect a start during the second stop bit or the remaining half bit.
  - If the stop bit is sampled 0, go to BREAK. Leave BREAK only when rx_s==1. A held-low line yields exactly one framing-error character.
- Output buffer without FIFO: single holding register {framing, parity, data}.
  - A completed character loads the register if rx_valid==0 or a pop occurs in the same cycle.
  - Otherwise the new character is dropped and overrun_error pulses. The held character is kept.
- Errored characters are delivered like good ones; the flags accompany them.

## Timing
- TX: tx falls on the cycle after the handshake.
- TX frame length is CLK_DIV×(1+DATA_BITS+P+STOP_BITS) cycles, where P=1 if PARITY≠0.
- tx_ready rises on the cycle after the last stop cycle. Back-to-back frames therefore have a minimum of one extra idle-high cycle between them.
- RX: rx_valid asserts on the cycle after the stop-bit sample.
- From the rx falling edge to mid-start is 2 synchroniser cycles + CLK_DIV/2.
- rx_data and the error flags are stable while rx_valid=1 and no pop occurs.

## Configuration
- UART_RX_FIFO_EN defined:
  - The holding register is replaced by a first-word-fall-through FIFO of RX_FIFO_DEPTH entries, each {framing, parity, data[7:0]}.
  - rx_valid = !empty. Push and pop in the same cycle are always allowed, including when full.
  - Overrun occurs when full with no pop in that cycle; the new character is dropped and overrun_error pulses.
- UART_RX_FIFO_EN undefined: single holding register as described in Operation. RX_FIFO_DEPTH is ignored.

## Structure
- Package uart_pkg holds:
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD
  - TX and RX state encodings
  - frame-length function bits_per_frame(DATA_BITS, PARITY, STOP_BITS)
- Sub-module uart_rx_fifo (synchronous FWFT FIFO, width 10, depth RX_FIFO_DEPTH) is instantiated only under UART_RX_FIFO_EN.
- The TX and RX FSMs stay inline.

## Test plan
All scenarios use CLK_DIV=16.
- 7E1, send 0x41:
  - tx low 16 cycles, then data bits 1,0,0,0,0,0,1 (LSB first), parity 0, stop 1.
  - tx_ready returns 161 cycles after the handshake.
- 8O2 loopback (tx→rx), send 0x55 then 0xA3 with tx_valid held:
  - rx_valid twice with 0x55 and 0xA3.
  - All error outputs stay 0.
- 7E1, drive rx frame 0x41 with parity bit 1 → rx_data=0x41, parity_error=1, framing_error=0.
- Stop bit 0 followed by rx held low for 200 cycles:
  - exactly one rx_valid, with framing_error=1
  - no further frames until rx returns high
- rx low for 6 cycles only → no rx_valid. A valid frame afterwards is received correctly.
- rx_ready=0 with 5 frames received:
  - Without FIFO: first character held, overrun_error pulses 4 times.
  - With UART_RX_FIFO_EN and depth 4: 4 characters popped in order, 1 overrun pulse.
